// File: rtl/tri_voice_scheduler.sv
// tri_voice_scheduler
//   Time-multiplexed rate controller for a bank of triangle-wave oscillators.
//   One voice is serviced per clock in round-robin order; each voice has a
//   divider, a down-counter and an on bit.  A voice whose counter is zero in
//   its slot emits a one-cycle ena pulse and reloads, giving a pulse period
//   of VOICES*(div+1) cycles.
//
//   Optional feature: define TRI_SCHED_GLIDE_EN for portamento.  WRITEs to a
//   running voice then set a target divider, and div steps one unit toward it
//   on every ena pulse of that voice.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cfg_valid/ready     config handshake (ready is low only while syncing)
//   cfg_op              0=WRITE 1=SYNC 2=MUTE_ALL 3=reserved (no effect)
//   cfg_voice/div/on    WRITE payload
//   ena[VOICES]         registered ena pulses, at most one bit high per cycle
//   active[VOICES]      per-voice on bits
module tri_voice_scheduler #(
   parameter int VOICES = 4,
   parameter int DIV_W  = 16,
   parameter int VID_W  = $clog2(VOICES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_op,
   input  logic [VID_W-1:0]  cfg_voice,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_on,
   output logic [VOICES-1:0] ena,
   output logic [VOICES-1:0] active
);
   localparam logic [1:0]       OP_WRITE = 2'd0;
   localparam logic [1:0]       OP_SYNC  = 2'd1;
   localparam logic [1:0]       OP_MUTE  = 2'd2;
   localparam logic [VID_W-1:0] LAST     = VID_W'(VOICES - 1);

   typedef enum logic {ST_RUN, ST_SYNC} state_t;

   state_t            state;
   logic [VID_W-1:0]  ptr;   // slot owner in RUN
   logic [VID_W-1:0]  s;     // sweep index in SYNC
   logic              acc, wr_acc, sync_acc, mute_acc, hold;
   logic [VOICES-1:0] fire, on;

   assign cfg_ready = (state == ST_RUN);
   assign acc       = cfg_valid & cfg_ready;
   assign wr_acc    = acc & (cfg_op == OP_WRITE);
   assign sync_acc  = acc & (cfg_op == OP_SYNC);
   assign mute_acc  = acc & (cfg_op == OP_MUTE);
   // No new pulse is launched in a cycle that mutes or starts a sweep, so
   // ena is quiet from the accepting edge onward.
   assign hold      = sync_acc | mute_acc;
   assign active    = on;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         ptr   <= '0;
         s     <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               ptr <= (ptr == LAST) ? '0 : ptr + VID_W'(1);
               if (sync_acc) begin
                  state <= ST_SYNC;
                  s     <= '0;
               end
            end
            ST_SYNC: begin
               if (s == LAST) begin
                  state <= ST_RUN;
                  ptr   <= '0;
               end else begin
                  s <= s + VID_W'(1);
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // svc is one-hot by construction (single ptr), so fire is at most one-hot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ena <= '0;
      else      ena <= fire;
   end

   for (genvar v = 0; v < VOICES; v++) begin : g_voice
      logic [DIV_W-1:0] div, cnt;
      logic             on_q, wr, svc, reload;

      // An out-of-range cfg_voice matches no lane and is silently dropped.
      assign wr      = wr_acc & (cfg_voice == VID_W'(v));
      // A write landing on the voice's own slot wins; the slot is skipped.
      assign svc     = (state == ST_RUN) & (ptr == VID_W'(v)) & ~wr & ~hold;
      assign reload  = (state == ST_SYNC) & (s == VID_W'(v));
      assign fire[v] = svc & on_q & (cnt == '0);
      assign on[v]   = on_q;

`ifdef TRI_SCHED_GLIDE_EN
      logic [DIV_W-1:0] tgt, step;

      always_comb begin
         step = div;
         if (div < tgt)      step = div + DIV_W'(1);
         else if (div > tgt) step = div - DIV_W'(1);
      end
`endif

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            div  <= '0;
            cnt  <= '0;
            on_q <= 1'b0;
`ifdef TRI_SCHED_GLIDE_EN
            tgt  <= '0;
`endif
         end else begin
            if (wr) begin
`ifdef TRI_SCHED_GLIDE_EN
               // Running voice: only retarget, the glide happens per pulse.
               if (on_q) begin
                  tgt <= cfg_div;
               end else begin
                  div <= cfg_div;
                  tgt <= cfg_div;
                  cnt <= cfg_div;
               end
`else
               div <= cfg_div;
               cnt <= cfg_div;
`endif
               on_q <= cfg_on;
            end else if (reload) begin
               cnt <= div;
            end else if (svc & on_q) begin
               if (cnt == '0) begin
`ifdef TRI_SCHED_GLIDE_EN
                  div <= step;
                  cnt <= step;
`else
                  cnt <= div;
`endif
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end
            if (mute_acc) on_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/tri_voice_scheduler.md
Name: tri_voice_scheduler

Overview:
- Time-multiplexed rate controller that drives the ena inputs of a bank of triangle-wave generators, one generator per synth voice.
- Holds a per-voice divider, on/off bit and down-counter, and services one voice per clock in round-robin order.
- Emits one-cycle ena pulses at each voice's programmed rate.
- Sits between the control/config logic (valid/ready writes) and the oscillator bank.

Parameters:
VOICES, 4, number of voices and ena outputs (2..16)
DIV_W, 16, width of divider and counter per voice
VID_W, $clog2(VOICES), width of voice index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request accepted when cfg_valid & cfg_ready
cfg_op  in  2  0=WRITE, 1=SYNC, 2=MUTE_ALL, 3=reserved
cfg_voice  in  VID_W  target voice for WRITE
cfg_div  in  DIV_W  divider value for WRITE
cfg_on  in  1  voice on bit for WRITE
ena  out  VOICES  one-hot-per-cycle ena pulses to oscillators
active  out  VOICES  registered copy of per-voice on bits

Behaviour:
- Reset (rst low, async): state=RUN, ptr=0, div/cnt/on all 0, ena=0, active=0. cfg_ready follows state, so it reads 1 once rst releases.
- Slot pointer ptr steps 0..VOICES-1 and wraps to 0, advancing every cycle in RUN.
- RUN slot service for voice v=ptr:
  - If on[v] and cnt[v]==0: ena[v]<=1 on the next edge and cnt[v]<=div[v].
  - Else if on[v]: cnt[v]<=cnt[v]-1.
  - Else: no change.
- ena is registered; at most one bit is high in any cycle.
- Pulse period for voice v = VOICES*(div[v]+1) cycles. div=0 gives one pulse per round.
- cfg_ready = (state==RUN), combinational from state only and independent of cfg_valid.
- WRITE (accepted): div[v]<=cfg_div, cnt[v]<=cfg_div, on[v]<=cfg_on, active[v] updates the same edge.
  - If cfg_voice==ptr in the same cycle, the write wins and no ena is generated for that slot this round.
  - cfg_voice >= VOICES: accepted and ignored.
- MUTE_ALL (accepted): all on<=0 and active<=0 at the same edge. div is kept, and any ena already registered still completes its single cycle.
- SYNC (accepted): state<=SYNC, sweep index s<=0.
  - Each SYNC cycle: cnt[s]<=div[s], no ena generated, cfg_ready=0.
  - After s==VOICES-1: state<=RUN, ptr<=0.
  - SYNC lasts exactly VOICES cycles; all voices are phase-aligned afterward.
- cfg_op=3: accepted, no effect.
- rst low mid-SYNC or mid-pulse: immediate return to reset values. No partial sweep completion.
- Counter arithmetic is unsigned DIV_W bits. cnt never decrements below 0 because the reload happens at 0.

Optional Feature:
Macro TRI_SCHED_GLIDE_EN (portamento).
- With it:
  - WRITE to a voice whose on bit is already 1 stores cfg_div into tgt[v]; div[v] is left unchanged.
  - Each time ena[v] fires, div[v] moves 1 toward tgt[v] (+1 or -1, holding when equal), and cnt reloads from the updated div.
  - WRITE to a voice with on=0 sets div=tgt=cnt=cfg_div directly.
  - SYNC and MUTE_ALL do not alter tgt.
- Without it: no tgt storage; WRITE replaces div immediately as described above.

Test Plan:
1. Release rst; WRITE v1 div=2 on=1, others off -> ena[1] first pulse within 12 cycles, then period exactly 12; ena[0,2,3]=0; active=4'b0010.
2. WRITE v0 div=0 on=1, WRITE v3 div=0 on=1 -> ena[0] and ena[3] each pulse every 4 cycles, 3 cycles apart; never both high.
3. v0 div=1, v2 div=3 running; issue SYNC -> cfg_ready low for exactly 4 cycles, ena all 0 during; afterward pulse phases match a fresh start from ptr=0.
4. WRITE v2 div=5 presented in the cycle ptr==2 while cnt[2]==0 -> no ena[2] that round; next ena[2] 24 cycles later at period 24.
5. Voices 0..3 on; MUTE_ALL -> active=0 next edge and no ena thereafter. Then pull rst low mid-SYNC -> ena, active=0 immediately and cfg_ready=1 after release.
6. (TRI_SCHED_GLIDE_EN) v2 on with div=10, then WRITE div=7 -> successive ena[2] periods 44,40,36,32,32 cycles.
